// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared state encoding and unit counts for the Morse transmit path
package morse_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_ARM      = 3'd1;
    localparam state_t S_MARK     = 3'd2;
    localparam state_t S_GAP      = 3'd3;
    localparam state_t S_CHAR_GAP = 3'd4;
    localparam state_t S_SPACE    = 3'd5;

    localparam logic [1:0] DOT_UNITS      = 2'd1;
    localparam logic [1:0] DASH_UNITS     = 2'd3;
    localparam logic [1:0] SYM_GAP_UNITS  = 2'd1;
    localparam logic [1:0] CHAR_GAP_UNITS = 2'd3;

    // The code register reloads its counter with SPACE_UNITS when it sees SPACE_LEN.
    localparam logic [3:0] SPACE_LEN   = 4'd0;
    localparam logic [3:0] SPACE_UNITS = 4'd7;

    function automatic logic [1:0] mark_units(input logic dash);
        return dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_tx_ctrl_if.sv
// rtl/morse_tx_ctrl_if.sv - character handshake between the character source and the controller
interface morse_tx_ctrl_if;

    logic       char_valid;
    logic [3:0] char_len;
    logic       char_ready;

    modport master (
        output char_valid,
        output char_len,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_len,
        output char_ready
    );

endinterface

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - intra-unit cycle counter with a pulse on the last cycle of each unit
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12500000,
    parameter int TMR_W       = $clog2(UNIT_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic unit_end
);

    logic [TMR_W-1:0] cyc;

    assign unit_end = (cyc == TMR_W'(UNIT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc <= '0;
        end else if (restart || unit_end) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + TMR_W'(1);
        end
    end

endmodule

// File: rtl/morse_tx_ctrl.sv
// rtl/morse_tx_ctrl.sv - Morse keying FSM driving the code register's load and shift strobes
module morse_tx_ctrl
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12500000
) (
    input  logic             clock,
    input  logic             reset,
    morse_tx_ctrl_if.slave   chr,
    input  logic             shft_data,
    input  logic [3:0]       cntr_data,
    output logic             char_load,
    output logic             shft_cnt,
    output logic             morse_out,
    output logic             busy
);

    localparam int TMR_W = $clog2(UNIT_CYCLES);

    state_t     state, state_nxt;
    logic [1:0] units, units_nxt;
    logic       is_space, is_space_nxt;
    logic       unit_end;
    logic       restart;
    logic       last_unit;

    // The timer sits at zero until the first MARK/SPACE cycle, so units align with state entry.
    assign restart   = (state == S_IDLE) || (state == S_ARM);
    assign last_unit = unit_end && (units == 2'd1);

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (restart),
        .unit_end (unit_end)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            units     <= '0;
            is_space  <= 1'b0;
            morse_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            units     <= units_nxt;
            is_space  <= is_space_nxt;
            morse_out <= (state_nxt == S_MARK);
        end
    end

    always_comb begin
        state_nxt    = state;
        units_nxt    = units;
        is_space_nxt = is_space;
        case (state)
            S_IDLE: begin
                if (chr.char_valid) begin
                    is_space_nxt = (chr.char_len == SPACE_LEN);
                    state_nxt    = S_ARM;
                end
            end
            S_ARM: begin
                if (is_space) begin
                    state_nxt = S_SPACE;
                end else if (cntr_data == 4'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_MARK;
                    units_nxt = mark_units(shft_data);
                end
            end
            S_MARK: begin
                if (last_unit) begin
                    // cntr_data is still the pre-shift count here
                    if (cntr_data == 4'd1) begin
                        state_nxt = S_CHAR_GAP;
                        units_nxt = CHAR_GAP_UNITS;
                    end else begin
                        state_nxt = S_GAP;
                        units_nxt = SYM_GAP_UNITS;
                    end
                end else if (unit_end) begin
                    units_nxt = units - 2'd1;
                end
            end
            S_GAP: begin
                if (last_unit) begin
                    state_nxt = S_MARK;
                    units_nxt = mark_units(shft_data);
                end else if (unit_end) begin
                    units_nxt = units - 2'd1;
                end
            end
            S_CHAR_GAP: begin
                if (last_unit) begin
                    state_nxt = S_IDLE;
                end else if (unit_end) begin
                    units_nxt = units - 2'd1;
                end
            end
            S_SPACE: begin
                if (unit_end && (cntr_data == 4'd1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        chr.char_ready = (state == S_IDLE);
        char_load      = (state == S_IDLE) && chr.char_valid && reset;
        shft_cnt       = ((state == S_MARK) && last_unit) || ((state == S_SPACE) && unit_end);
        busy           = (state != S_IDLE);
    end

endmodule

// File: doc/morse_tx_ctrl.md
Name: morse_tx_ctrl

Overview:
- Timing controller for the Morse encoder datapath; sits directly downstream of the code register (charcode/charlen shifter + counter).
- Accepts one character per valid/ready handshake from the character source and drives the code register's char_load and shft_cnt.
- Reads back the current symbol (shft_data, MSB of shifter) and the remaining count (cntr_data), and produces the keyed Morse output with ITU unit timing.

Parameters:
- UNIT_CYCLES, 12500000, clock cycles per Morse time unit; must be >=2. Bench overrides it to 4.
- TMR_W, $clog2(UNIT_CYCLES), width of the intra-unit cycle timer (derived, not overridden).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- char_valid  in  1  upstream has a character on charcode_data/charlen_data (those buses go straight to the code register).
- char_len  in  4  copy of charlen_data; 0 marks a word space.
- char_ready  out  1  controller can accept a character.
- shft_data  in  1  current symbol from code register: 1 = dash, 0 = dot.
- cntr_data  in  4  symbols (or space units) remaining, from code register.
- char_load  out  1  load strobe to code register.
- shft_cnt  out  1  shift/decrement strobe to code register.
- morse_out  out  1  keyed output: 1 = tone/LED on.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE, timers 0, space flag 0, morse_out=0. Outputs during reset: char_ready=1, char_load=0, shft_cnt=0, busy=0.
- States: IDLE, ARM, MARK, GAP, CHAR_GAP, SPACE.
- Timer: cyc counts 0..UNIT_CYCLES-1, and a unit_end pulse fires at UNIT_CYCLES-1. units counts units left in the current state (2 bits suffice: max 3).
- IDLE:
  - char_ready=1.
  - char_load = char_valid (combinational, only in IDLE); the handshake cycle is the load cycle.
  - On handshake: latch is_space=(char_len==0) and go to ARM.
- ARM (1 cycle; code register now holds the new character):
  - If is_space, go to SPACE.
  - Else if cntr_data==0, go to IDLE (defensive, no output).
  - Else go to MARK with units = shft_data ? 3 : 1.
- MARK:
  - morse_out=1, registered, so high exactly while in MARK.
  - On the last cycle of the last unit: shft_cnt=1 for that one cycle.
  - Next state uses the pre-decrement cntr_data: if cntr_data==1, go to CHAR_GAP (3 units); else go to GAP (1 unit).
- GAP: morse_out=0. After 1 unit, go to MARK with units = shft_data ? 3 : 1, using the already-shifted shft_data.
- CHAR_GAP: morse_out=0. After 3 units, go to IDLE.
- SPACE:
  - morse_out=0. shft_cnt pulses on the last cycle of every unit; the code register counts the 7 blanks.
  - At a unit end with cntr_data==1, go to IDLE. A space is 7 units total, emitted after the preceding char's 3-unit gap.
- Latency:
  - Handshake at edge t: ARM during t..t+1, and morse_out rises after edge t+1.
  - Accept-to-ready = 1 + sum of mark/gap units × UNIT_CYCLES.
- char_valid while busy: ignored; char_load stays 0. Upstream holds data stable while char_valid=1 until char_load.
- char_len >8 (non-zero): shifted-in zeros emit as dots; this is an upstream error, not checked.
- shft_cnt and char_load are never high in the same cycle.
- Reset mid-character: immediate abort; morse_out=0 asynchronously; no shft_cnt pulse.

Decomposition:
- Shared package morse_pkg holds:
  - state encoding (3-bit localparams S_IDLE..S_SPACE);
  - DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, CHAR_GAP_UNITS=3;
  - SPACE_LEN=4'd0 and SPACE_UNITS=4'd7, shared with the code register's space reload.
- One sub-module, morse_unit_timer: cycle counter with restart input and unit_end output, parameterised by UNIT_CYCLES.

Test Plan (UNIT_CYCLES=4, code register instantiated alongside):
- Reset: assert reset=0 mid-cycle -> morse_out=0, char_ready=1, char_load=0, shft_cnt=0, busy=0 immediately.
- "E" (code 8'h00, len 1):
  - char_load high 1 cycle; morse_out high 4 cycles.
  - One shft_cnt in the 4th high cycle; then low 12 cycles; char_ready=1 exactly 17 cycles after accept.
- "A" (code 8'b0100_0000, len 2):
  - morse_out pattern 4 high, 4 low, 12 high, 12 low.
  - Two shft_cnt pulses, at cycles 4 and 20 after ARM.
- Space (len 0):
  - morse_out low for 28 cycles.
  - Seven shft_cnt pulses spaced 4 cycles; IDLE after the 7th.
- Back-to-back: char_valid held with "T" (8'h80, len 1) then "E":
  - No char_load while busy.
  - "E" loads in the first cycle char_ready returns: T = 12 high + 12 low, then E.
- Reset released mid-dash: reset=0 at 6th high cycle of a dash -> morse_out drops at once; after release, IDLE, char_ready=1, next char encodes normally.
